// File: rtl/sum_bcd_converter_pkg.sv
// Shared types and constants for the sum-to-BCD converter.
//   state_t    : converter FSM states
//   DEF_WIDTH  : default binary input width (8+8-bit adder sum)
//   DEF_DIGITS : default number of BCD output digits
//   DIG_W      : bits per BCD digit
package sum_bcd_pkg;
  localparam int DEF_WIDTH  = 9;
  localparam int DEF_DIGITS = 3;
  localparam int DIG_W      = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/sum_bcd_converter_if.sv
// Handshake bundle between the adder, the converter and the display driver.
//   in_valid/in_ready/sum      : binary sum input channel
//   out_valid/out_ready/bcd    : packed BCD result channel ([3:0] = ones)
//   busy                       : conversion in progress
// slave  = converter side, master = producer/consumer side.
interface sum_bcd_converter_if
  import sum_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          sum;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIG_W*DIGITS-1:0]   bcd;
  logic                      busy;

  modport slave (
    input  in_valid, sum, out_ready,
    output in_ready, out_valid, bcd, busy
  );

  modport master (
    output in_valid, sum, out_ready,
    input  in_ready, out_valid, bcd, busy
  );
endinterface

// File: rtl/sum_bcd_converter_digit_adj.sv
// Double-dabble correction cell: a BCD digit >= 5 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   d : digit before correction
//   q : corrected digit
module bcd_digit_adj
  import sum_bcd_pkg::*;
(
  input  logic [DIG_W-1:0] d,
  output logic [DIG_W-1:0] q
);
  assign q = (d >= DIG_W'(5)) ? d + DIG_W'(3) : d;
endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sum_bcd_converter_if.slave (sum in, packed BCD out, busy)
// A sum is accepted in IDLE, shifted in over WIDTH cycles in SHIFT, and the
// registered result is presented in DONE until the consumer takes it.
module sum_bcd_converter
  import sum_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
)(
  input  logic               clk,
  input  logic               reset,
  sum_bcd_converter_if.slave bus
);
  localparam int BW = DIG_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // Result must fit: largest WIDTH-bit value needs fewer than 10^DIGITS.
  if ((10 ** DIGITS) <= (2 ** WIDTH) - 1) begin : g_bad_digits
    $error("DIGITS too small for WIDTH");
  end

  state_t                         state, state_nxt;
  logic [WIDTH-1:0]               bin_sr;
  logic [DIGITS-1:0][DIG_W-1:0]   bcd_sr, bcd_adj;
  logic [CW-1:0]                  cnt;
  logic [BW-1:0]                  bcd_q;
  logic [BW+WIDTH-1:0]            shifted;
  logic [BW-1:0]                  bcd_nxt;
  logic                           last;

  // All digits corrected in parallel from the pre-shift value.
  bcd_digit_adj u_adj [DIGITS-1:0] (.d(bcd_sr), .q(bcd_adj));

  assign shifted = {bcd_adj, bin_sr} << 1;
  assign bcd_nxt = shifted[BW+WIDTH-1:WIDTH];
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          bin_sr <= bus.sum;
          bcd_sr <= '0;
          cnt    <= CW'(WIDTH);
        end
        SHIFT: begin
          bcd_sr <= bcd_nxt;
          bin_sr <= shifted[WIDTH-1:0];
          cnt    <= cnt - CW'(1);
          // Output register updates only on the edge that enters DONE.
          if (last) bcd_q <= bcd_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == SHIFT);
  assign bus.bcd       = bcd_q;
endmodule

// File: tb/tb_sum_bcd_converter.sv
module tb_sum_bcd_converter;
  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   acc_cyc;
  int   prev_acc;
  logic [11:0] last_bcd;

  sum_bcd_converter_if #(.WIDTH(9), .DIGITS(3)) bus ();

  sum_bcd_converter #(.WIDTH(9), .DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Inputs driven and outputs sampled on the falling edge.
  // inj: edge count after accept at which a stray in_valid (sum=456) is pulsed.
  task automatic conv(input int s, input int stall, input int inj);
    int n;
    logic [11:0] exp;
    exp = ref_bcd(s);
    n = 0;
    while (!bus.in_ready && n < 30) begin @(negedge clk); n++; end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.sum       = 9'(s);
    bus.out_ready = (stall == 0);
    @(negedge clk);
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    chk("busy_after_acc", bus.busy, 1);
    chk("in_ready_busy", bus.in_ready, 0);
    chk("bcd_hold", bus.bcd, last_bcd);
    n = 1;
    while (!bus.out_valid && n < 30) begin
      bus.in_valid = (n == inj);
      if (n == inj) bus.sum = 9'd456;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    chk("latency", n, 10);
    chk("bcd_result", bus.bcd, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_bcd", bus.bcd, exp);
      chk("stall_rdy", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("consumed", bus.out_valid, 0);
    chk("ready_back", bus.in_ready, 1);
    last_bcd = exp;
  endtask

  initial begin
    int seq[6];
    seq = '{9, 10, 99, 100, 255, 511};
    reset = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sum       = 9'd77;
    bus.out_ready = 1'b0;
    last_bcd = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_bcd", bus.bcd, 0);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_acc", bus.busy, 0);

    conv(0, 0, 0);

    prev_acc = -1;
    foreach (seq[i]) begin
      conv(seq[i], 0, 0);
      if (prev_acc >= 0) chk("spacing", acc_cyc - prev_acc, 11);
      prev_acc = acc_cyc;
    end

    conv(300, 20, 0);

    // Stray in_valid during SHIFT must be ignored.
    conv(123, 0, 3);
    repeat (3) begin
      @(negedge clk);
      chk("no_reaccept", bus.busy, 0);
      chk("idle_ready", bus.in_ready, 1);
    end

    // Reset on SHIFT cycle 5 of sum=511.
    bus.in_valid = 1'b1;
    bus.sum      = 9'd511;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_bcd", bus.bcd, 0);
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_busy", bus.busy, 0);
    last_bcd = '0;
    conv(42, 0, 0);

    for (int v = 0; v < 512; v++) conv(v, $urandom_range(0, 2), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
